// File: rtl/active_list_pkg.sv
// Active-list pipeline package: shared widths and entry layout.
// Also used by the pipeline registers that carry active_list_index.
package active_list_pkg;

  localparam int REG_ADDR_WIDTH  = 5;
  localparam int FREE_LIST_WIDTH = 3;
  localparam int AL_DEPTH        = 2**FREE_LIST_WIDTH;

  typedef logic [FREE_LIST_WIDTH-1:0] al_index_t;

  typedef struct packed {
    logic                      valid;
    logic                      done;
    logic                      has_dest;
    logic [REG_ADDR_WIDTH-1:0] virtual_addr;
    logic [REG_ADDR_WIDTH:0]   new_phys;
    logic [REG_ADDR_WIDTH:0]   old_phys;
  } al_entry_t;

endpackage

// File: rtl/active_list.sv
// In-order retirement tracker: circular buffer of renamed instructions.
// Allocates at tail, marks completions by index, retires from head.
module active_list
  import active_list_pkg::*;
#(
  parameter int REG_ADDR_WIDTH  = active_list_pkg::REG_ADDR_WIDTH,
  parameter int FREE_LIST_WIDTH = active_list_pkg::FREE_LIST_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       alloc_valid,
  output logic                       alloc_ready,
  input  logic                       alloc_has_dest,
  input  logic [REG_ADDR_WIDTH-1:0]  alloc_virtual_addr,
  input  logic [REG_ADDR_WIDTH:0]    alloc_new_phys,
  input  logic [REG_ADDR_WIDTH:0]    alloc_old_phys,
  output logic [FREE_LIST_WIDTH-1:0] alloc_index,
  input  logic                       done_valid,
  input  logic [FREE_LIST_WIDTH-1:0] done_index,
  input  logic                       commit_stall,
  output logic                       commit_valid,
  output logic                       commit_has_dest,
  output logic [REG_ADDR_WIDTH-1:0]  commit_virtual_addr,
  output logic [REG_ADDR_WIDTH:0]    commit_physical_addr,
  output logic [REG_ADDR_WIDTH:0]    commit_free_phys,
  output logic [FREE_LIST_WIDTH:0]   count,
  output logic                       empty,
  output logic                       full
);

  localparam int DEPTH = 2**FREE_LIST_WIDTH;
  localparam logic [FREE_LIST_WIDTH:0] DEPTH_C = DEPTH[FREE_LIST_WIDTH:0];

  typedef struct packed {
    logic                      valid;
    logic                      done;
    logic                      has_dest;
    logic [REG_ADDR_WIDTH-1:0] virtual_addr;
    logic [REG_ADDR_WIDTH:0]   new_phys;
    logic [REG_ADDR_WIDTH:0]   old_phys;
  } entry_t;

  entry_t                     mem [DEPTH];
  entry_t                     head_e;
  logic [FREE_LIST_WIDTH-1:0] head;
  logic [FREE_LIST_WIDTH-1:0] tail;
  logic [FREE_LIST_WIDTH:0]   cnt;
  logic                       do_alloc;
  logic                       do_done;
  logic                       do_retire;

  assign full        = (cnt == DEPTH_C);
  assign empty       = (cnt == '0);
  assign count       = cnt;
  assign alloc_ready = !full;
  assign alloc_index = tail;
  assign head_e      = mem[head];

  // Accept/complete/retire qualifiers; flush suppresses all three.
  always_comb begin
    do_alloc  = alloc_valid && !full && !flush;
    do_done   = done_valid && mem[done_index].valid && !flush;
    do_retire = head_e.valid && head_e.done && !commit_stall && !flush;
  end

  // Entry storage: completion, retire clear, then tail write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i].valid <= 1'b0;
        mem[i].done  <= 1'b0;
      end
    end else begin
      if (do_done) mem[done_index].done <= 1'b1;
      if (do_retire) mem[head] <= '0;
      if (do_alloc) begin
        mem[tail].valid        <= 1'b1;
        mem[tail].done         <= 1'b0;
        mem[tail].has_dest     <= alloc_has_dest;
        mem[tail].virtual_addr <= alloc_virtual_addr;
        mem[tail].new_phys     <= alloc_new_phys;
        mem[tail].old_phys     <= alloc_old_phys;
      end
    end
  end

  // Head/tail pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (do_alloc) tail <= tail + 1'b1;
      if (do_retire) head <= head + 1'b1;
      unique case ({do_alloc, do_retire})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Registered retire port; data holds when nothing retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_valid         <= 1'b0;
      commit_has_dest      <= 1'b0;
      commit_virtual_addr  <= '0;
      commit_physical_addr <= '0;
      commit_free_phys     <= '0;
    end else begin
      commit_valid <= do_retire;
      if (do_retire) begin
        commit_has_dest      <= head_e.has_dest;
        commit_virtual_addr  <= head_e.virtual_addr;
        commit_physical_addr <= head_e.new_phys;
        commit_free_phys     <= head_e.old_phys;
      end
    end
  end

endmodule

// File: tb/tb_active_list.sv
// Self-checking bench for active_list.
// Expected retires are queued at allocation, checked at commit.
module tb_active_list;

  localparam int AW = 5;
  localparam int FW = 3;
  localparam int PW = AW + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          alloc_valid = 1'b0;
  logic          alloc_ready;
  logic          alloc_has_dest = 1'b0;
  logic [AW-1:0] alloc_virtual_addr = '0;
  logic [PW-1:0] alloc_new_phys = '0;
  logic [PW-1:0] alloc_old_phys = '0;
  logic [FW-1:0] alloc_index;
  logic          done_valid = 1'b0;
  logic [FW-1:0] done_index = '0;
  logic          commit_stall = 1'b0;
  logic          commit_valid;
  logic          commit_has_dest;
  logic [AW-1:0] commit_virtual_addr;
  logic [PW-1:0] commit_physical_addr;
  logic [PW-1:0] commit_free_phys;
  logic [FW:0]   count;
  logic          empty;
  logic          full;

  typedef struct packed {
    logic          hd;
    logic [AW-1:0] v;
    logic [PW-1:0] np;
    logic [PW-1:0] op;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  active_list #(.REG_ADDR_WIDTH(AW), .FREE_LIST_WIDTH(FW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_has_dest(alloc_has_dest),
    .alloc_virtual_addr(alloc_virtual_addr),
    .alloc_new_phys(alloc_new_phys),
    .alloc_old_phys(alloc_old_phys),
    .alloc_index(alloc_index),
    .done_valid(done_valid), .done_index(done_index),
    .commit_stall(commit_stall), .commit_valid(commit_valid),
    .commit_has_dest(commit_has_dest),
    .commit_virtual_addr(commit_virtual_addr),
    .commit_physical_addr(commit_physical_addr),
    .commit_free_phys(commit_free_phys),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  // Scoreboard: every retire pulse must match the oldest queued entry.
  always @(negedge clk) begin
    exp_t e;
    exp_t g;
    if (rst_n && commit_valid) begin
      vectors++;
      g = {commit_has_dest, commit_virtual_addr,
           commit_physical_addr, commit_free_phys};
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_commit got %h required none", g);
      end else begin
        e = exp_q.pop_front();
        if (g !== e) begin
          miscompares++;
          $display("FAIL commit_data got %h required %h", g, e);
        end
      end
    end
  end

  task automatic alloc(input logic hd, input logic [AW-1:0] v,
                       input logic [PW-1:0] np, input logic [PW-1:0] op);
    logic ok;
    alloc_valid = 1'b1;
    alloc_has_dest = hd;
    alloc_virtual_addr = v;
    alloc_new_phys = np;
    alloc_old_phys = op;
    ok = alloc_ready;
    @(posedge clk);
    if (ok) exp_q.push_back({hd, v, np, op});
    #1 alloc_valid = 1'b0;
  endtask

  task automatic complete(input logic [FW-1:0] idx);
    done_valid = 1'b1;
    done_index = idx;
    @(posedge clk);
    #1 done_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_empty(input int bound);
    int n = 0;
    while (!empty && n < bound) begin
      @(posedge clk);
      #1 n++;
    end
    vectors++;
    if (!empty) begin
      miscompares++;
      $display("FAIL wait_empty got count=%0d required 0", count);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    vectors++;
    if ({count, empty, full, alloc_ready, alloc_index} !== {4'd0, 1'b1, 1'b0, 1'b1, 3'd0}) begin
      miscompares++;
      $display("FAIL reset_status got cnt=%0d e=%b f=%b r=%b idx=%0d required 0 1 0 1 0",
               count, empty, full, alloc_ready, alloc_index);
    end
    vectors++;
    if ({commit_valid, commit_has_dest, commit_virtual_addr,
         commit_physical_addr, commit_free_phys} !== '0) begin
      miscompares++;
      $display("FAIL reset_commit got v=%b a=%0d p=%0d f=%0d required 0",
               commit_valid, commit_virtual_addr, commit_physical_addr, commit_free_phys);
    end
    alloc(1'b1, 5'd9, 6'd50, 6'd9);
    alloc(1'b1, 5'd10, 6'd51, 6'd10);
    complete(3'd0);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    vectors++;
    if ({commit_valid, count, alloc_index} !== {1'b0, 4'd0, 3'd0}) begin
      miscompares++;
      $display("FAIL reset_midop got cv=%b cnt=%0d idx=%0d required 0 0 0",
               commit_valid, count, alloc_index);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single();
    vectors++;
    if (alloc_index !== 3'd0) begin
      miscompares++;
      $display("FAIL single_idx got %0d required 0", alloc_index);
    end
    alloc(1'b1, 5'd3, 6'd40, 6'd3);
    @(negedge clk);
    vectors++;
    if ({count, alloc_index} !== {4'd1, 3'd1}) begin
      miscompares++;
      $display("FAIL single_alloc got cnt=%0d idx=%0d required 1 1", count, alloc_index);
    end
    complete(3'd0);
    @(negedge clk);
    vectors++;
    if (commit_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_early got cv=%b required 0", commit_valid);
    end
    @(negedge clk);
    vectors++;
    if ({commit_valid, count} !== {1'b1, 4'd0}) begin
      miscompares++;
      $display("FAIL single_retire got cv=%b cnt=%0d required 1 0", commit_valid, count);
    end
    idle(1);
  endtask

  task automatic test_back_to_back();
    logic [FW-1:0] b;
    b = alloc_index;
    alloc(1'b1, 5'd1, 6'd33, 6'd1);
    alloc(1'b0, 5'd2, 6'd34, 6'd2);
    alloc(1'b1, 5'd4, 6'd35, 6'd4);
    complete(b + 3'd2);
    complete(b + 3'd1);
    @(negedge clk);
    vectors++;
    if ({commit_valid, count} !== {1'b0, 4'd3}) begin
      miscompares++;
      $display("FAIL ooo_hold got cv=%b cnt=%0d required 0 3", commit_valid, count);
    end
    complete(b);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (commit_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL ooo_pulse%0d got cv=%b required 1", i, commit_valid);
      end
    end
    idle(1);
    vectors++;
    if (exp_q.size() != 0 || count !== 4'd0) begin
      miscompares++;
      $display("FAIL ooo_drain got q=%0d cnt=%0d required 0 0", exp_q.size(), count);
    end
  endtask

  task automatic test_full_wrap();
    apply_reset();
    for (int i = 0; i < 8; i++)
      alloc(1'b1, 5'(i + 8), 6'(i + 32), 6'(i));
    @(negedge clk);
    vectors++;
    if ({full, alloc_ready, count} !== {1'b1, 1'b0, 4'd8}) begin
      miscompares++;
      $display("FAIL full_state got f=%b r=%b cnt=%0d required 1 0 8",
               full, alloc_ready, count);
    end
    alloc(1'b1, 5'd30, 6'd60, 6'd30);
    @(negedge clk);
    vectors++;
    if (count !== 4'd8) begin
      miscompares++;
      $display("FAIL full_ninth got cnt=%0d required 8", count);
    end
    complete(3'd0);
    idle(1);
    @(negedge clk);
    vectors++;
    if ({count, full, alloc_index} !== {4'd7, 1'b0, 3'd0}) begin
      miscompares++;
      $display("FAIL wrap_state got cnt=%0d f=%b idx=%0d required 7 0 0",
               count, full, alloc_index);
    end
    alloc(1'b1, 5'd20, 6'd61, 6'd20);
    @(negedge clk);
    vectors++;
    if ({alloc_index, count} !== {3'd1, 4'd8}) begin
      miscompares++;
      $display("FAIL wrap_alloc got idx=%0d cnt=%0d required 1 8", alloc_index, count);
    end
    for (int i = 1; i < 8; i++) complete(3'(i));
    complete(3'd0);
    wait_empty(20);
  endtask

  task automatic test_stall();
    logic [FW-1:0] idx;
    idx = alloc_index;
    alloc(1'b1, 5'd7, 6'd45, 6'd7);
    commit_stall = 1'b1;
    complete(idx);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (commit_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold%0d got cv=%b required 0", i, commit_valid);
      end
    end
    commit_stall = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({commit_valid, count} !== {1'b1, 4'd0}) begin
      miscompares++;
      $display("FAIL stall_release got cv=%b cnt=%0d required 1 0", commit_valid, count);
    end
    idle(1);
  endtask

  task automatic test_flush();
    logic [FW-1:0] b;
    b = alloc_index;
    for (int i = 0; i < 5; i++)
      alloc(1'b1, 5'(i + 16), 6'(i + 40), 6'(i + 16));
    complete(b + 3'd2);
    complete(b + 3'd3);
    flush = 1'b1;
    alloc_valid = 1'b1;
    done_valid = 1'b1;
    done_index = b;
    @(posedge clk);
    exp_q.delete();
    #1;
    flush = 1'b0;
    alloc_valid = 1'b0;
    done_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({count, empty, alloc_index, commit_valid} !== {4'd0, 1'b1, 3'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL flush_state got cnt=%0d e=%b idx=%0d cv=%b required 0 1 0 0",
               count, empty, alloc_index, commit_valid);
    end
    idle(3);
  endtask

  task automatic test_edge_complete();
    alloc(1'b1, 5'd11, 6'd12, 6'd13);
    alloc(1'b0, 5'd14, 6'd15, 6'd16);
    complete(3'd5);
    idle(2);
    @(negedge clk);
    vectors++;
    if ({count, commit_valid} !== {4'd2, 1'b0}) begin
      miscompares++;
      $display("FAIL invalid_done got cnt=%0d cv=%b required 2 0", count, commit_valid);
    end
    done_valid = 1'b1;
    done_index = 3'd2;
    alloc(1'b1, 5'd17, 6'd18, 6'd19);
    done_valid = 1'b0;
    complete(3'd0);
    complete(3'd1);
    idle(4);
    vectors++;
    if (count !== 4'd1 || exp_q.size() != 1) begin
      miscompares++;
      $display("FAIL same_cycle_done got cnt=%0d q=%0d required 1 1", count, exp_q.size());
    end
    complete(3'd2);
    wait_empty(10);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_wrap();
    test_stall();
    test_flush();
    test_edge_complete();
    idle(2);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover_expected got %0d required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
